// File: rtl/vfr_sched_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding and a
// constant-foldable ceil(log2) helper used to size the burst length field.
package vfr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_ISSUE,
        ST_DRAIN
    } sched_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vfr_frame_scheduler.sv
// Frame read scheduler: splits each frame into MAX_BURST-sized read commands,
// counts returned words and signals end of frame, optionally repeating.
module vfr_frame_scheduler
    import vfr_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORDS_WIDTH    = 24,
    parameter int unsigned MAX_BURST      = 32,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go,
    input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
    input  logic [WORDS_WIDTH-1:0]      cfg_words,
    input  logic                        cfg_one_shot,
    input  logic                        cfg_commit,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [ADDR_WIDTH-1:0]       cmd_addr,
    output logic [clog2(MAX_BURST):0]   cmd_len,
    input  logic                        rd_done,
    output logic                        frame_irq,
    output logic                        clear_go,
    output logic                        stopped
);

    localparam int unsigned LEN_W = clog2(MAX_BURST) + 1;
    localparam logic [WORDS_WIDTH-1:0] BURST_W = WORDS_WIDTH'(MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0]  BPW_A   = ADDR_WIDTH'(BYTES_PER_WORD);

    sched_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pend_base_q, pend_base_d;
    logic [WORDS_WIDTH-1:0] pend_words_q, pend_words_d;
    logic                   pend_one_shot_q, pend_one_shot_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   act_one_shot_q, act_one_shot_d;
    logic [WORDS_WIDTH-1:0] cmd_rem_q, cmd_rem_d;
    logic [WORDS_WIDTH-1:0] data_rem_q, data_rem_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]       cmd_len_q, cmd_len_d;
    logic                   frame_irq_q, frame_irq_d;
    logic                   clear_go_q, clear_go_d;
    logic                   stopped_q, stopped_d;

    logic                   accept;
    logic                   rd_dec;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic [WORDS_WIDTH-1:0] rem_next;
    logic [WORDS_WIDTH-1:0] data_next;
    logic [WORDS_WIDTH-1:0] burst_rem;
    logic [LEN_W-1:0]       burst_len;

    always_comb begin
        state_d         = state_q;
        pend_base_d     = pend_base_q;
        pend_words_d    = pend_words_q;
        pend_one_shot_d = pend_one_shot_q;
        pend_valid_d    = pend_valid_q;
        act_one_shot_d  = act_one_shot_q;
        cmd_rem_d       = cmd_rem_q;
        data_rem_d      = data_rem_q;
        cmd_valid_d     = cmd_valid_q;
        cmd_addr_d      = cmd_addr_q;
        cmd_len_d       = cmd_len_q;
        frame_irq_d     = 1'b0;
        clear_go_d      = 1'b0;

        if (cfg_commit) begin
            if (cfg_words != '0) begin
                pend_base_d     = cfg_base_addr;
                pend_words_d    = cfg_words;
                pend_one_shot_d = cfg_one_shot;
                pend_valid_d    = 1'b1;
            end else begin
                pend_valid_d    = 1'b0;
            end
        end

        // cmd_addr_q doubles as the running frame address
        accept    = cmd_valid_q && cmd_ready;
        rd_dec    = rd_done && (data_rem_q != '0);
        addr_next = cmd_addr_q + ADDR_WIDTH'(cmd_len_q) * BPW_A;
        rem_next  = cmd_rem_q - WORDS_WIDTH'(cmd_len_q);
        data_next = data_rem_q - WORDS_WIDTH'(rd_dec);
        burst_rem = (state_q == ST_START) ? pend_words_q : rem_next;
        burst_len = (burst_rem >= BURST_W) ? LEN_W'(MAX_BURST) : burst_rem[LEN_W-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (go && pend_valid_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                act_one_shot_d = pend_one_shot_q;
                cmd_rem_d      = pend_words_q;
                data_rem_d     = pend_words_q - WORDS_WIDTH'(rd_done);
                cmd_valid_d    = 1'b1;
                cmd_addr_d     = pend_base_q;
                cmd_len_d      = burst_len;
                state_d        = ST_ISSUE;
            end
            ST_ISSUE: begin
                data_rem_d = data_next;
                if (accept) begin
                    cmd_rem_d  = rem_next;
                    cmd_addr_d = addr_next;
                    if (rem_next == '0) begin
                        cmd_valid_d = 1'b0;
                        state_d     = ST_DRAIN;
                    end else begin
                        cmd_len_d   = burst_len;
                    end
                end
            end
            ST_DRAIN: begin
                data_rem_d = data_next;
                if (data_next == '0) begin
                    frame_irq_d = 1'b1;
                    if (act_one_shot_q) begin
                        clear_go_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (go) begin
                        state_d    = ST_START;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        stopped_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            pend_base_q     <= '0;
            pend_words_q    <= '0;
            pend_one_shot_q <= 1'b0;
            pend_valid_q    <= 1'b0;
            act_one_shot_q  <= 1'b0;
            cmd_rem_q       <= '0;
            data_rem_q      <= '0;
            cmd_valid_q     <= 1'b0;
            cmd_addr_q      <= '0;
            cmd_len_q       <= '0;
            frame_irq_q     <= 1'b0;
            clear_go_q      <= 1'b0;
            stopped_q       <= 1'b1;
        end else begin
            state_q         <= state_d;
            pend_base_q     <= pend_base_d;
            pend_words_q    <= pend_words_d;
            pend_one_shot_q <= pend_one_shot_d;
            pend_valid_q    <= pend_valid_d;
            act_one_shot_q  <= act_one_shot_d;
            cmd_rem_q       <= cmd_rem_d;
            data_rem_q      <= data_rem_d;
            cmd_valid_q     <= cmd_valid_d;
            cmd_addr_q      <= cmd_addr_d;
            cmd_len_q       <= cmd_len_d;
            frame_irq_q     <= frame_irq_d;
            clear_go_q      <= clear_go_d;
            stopped_q       <= stopped_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign frame_irq = frame_irq_q;
    assign clear_go  = clear_go_q;
    assign stopped   = stopped_q;

endmodule

// File: tb/tb_vfr_frame_scheduler.sv
// Scoreboard bench for vfr_frame_scheduler: directed frames push expected
// commands and end-of-frame events; a negedge monitor pops and compares.
module tb_vfr_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [23:0] cfg_words = '0;
    logic        cfg_one_shot = 1'b0;
    logic        cfg_commit = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [31:0] cmd_addr;
    logic [5:0]  cmd_len;
    logic        rd_done = 1'b0;
    logic        frame_irq;
    logic        clear_go;
    logic        stopped;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr[$];
    int          exp_len[$];
    int          exp_irq_total[$];
    logic        exp_irq_cg[$];
    int          exp_total = 0;

    int          n_acc = 0;
    int          total_rd = 0;
    int          words_granted = 0;
    int          words_sent = 0;

    vfr_frame_scheduler #(
        .ADDR_WIDTH(32),
        .WORDS_WIDTH(24),
        .MAX_BURST(32),
        .BYTES_PER_WORD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .cfg_base_addr(cfg_base_addr),
        .cfg_words(cfg_words),
        .cfg_one_shot(cfg_one_shot),
        .cfg_commit(cfg_commit),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .rd_done(rd_done),
        .frame_irq(frame_irq),
        .clear_go(clear_go),
        .stopped(stopped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred or bound expired", name);
    endtask

    // Read master model: returns one word per owed word, with random gaps
    always @(posedge clk) begin
        #1;
        if (words_sent < words_granted && $urandom_range(0, 3) != 0) begin
            rd_done = 1'b1;
            words_sent++;
        end else begin
            rd_done = 1'b0;
        end
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [5:0]  prev_len = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", cmd_valid, 1);
                check("stall_addr", cmd_addr, prev_addr);
                check("stall_len", cmd_len, prev_len);
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_addr  = cmd_addr;
            prev_len   = cmd_len;
            if (cmd_valid && cmd_ready) begin
                if (exp_addr.size() == 0) begin
                    fail_event("unexpected_cmd");
                end else begin
                    check("cmd_addr", cmd_addr, exp_addr.pop_front());
                    check("cmd_len", cmd_len, exp_len.pop_front());
                end
                words_granted += int'(cmd_len);
                n_acc++;
            end
            if (frame_irq) begin
                if (exp_irq_total.size() == 0) begin
                    fail_event("unexpected_irq");
                end else begin
                    check("irq_words", total_rd, exp_irq_total.pop_front());
                    check("irq_clear_go", clear_go, exp_irq_cg.pop_front());
                end
            end else if (clear_go) begin
                fail_event("clear_go_without_irq");
            end
            if (rd_done) total_rd++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic commit(input logic [31:0] base, input logic [23:0] words, input logic os);
        cfg_base_addr = base;
        cfg_words     = words;
        cfg_one_shot  = os;
        cfg_commit    = 1'b1;
        tick(1);
        cfg_commit    = 1'b0;
    endtask

    task automatic expect_cmd(input logic [31:0] addr, input int len);
        exp_addr.push_back(addr);
        exp_len.push_back(len);
    endtask

    task automatic expect_irq(input int words, input logic cg);
        exp_total += words;
        exp_irq_total.push_back(exp_total);
        exp_irq_cg.push_back(cg);
    endtask

    task automatic wait_accepts(input int n, input string name);
        int b = 0;
        while (n_acc < n && b < 2000) begin
            tick(1);
            b++;
        end
        if (n_acc < n) fail_event(name);
    endtask

    task automatic wait_valid(input string name);
        int b = 0;
        while (!cmd_valid && b < 50) begin
            tick(1);
            b++;
        end
        if (!cmd_valid) fail_event(name);
    endtask

    task automatic wait_clear_go(input string name);
        int b = 0;
        while (!clear_go && b < 2000) begin
            tick(1);
            b++;
        end
        if (!clear_go) fail_event(name);
        go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while (!(stopped && exp_addr.size() == 0 && exp_irq_total.size() == 0) && b < 3000) begin
            tick(1);
            b++;
        end
        if (b >= 3000) fail_event(name);
        tick(5);
        check({name, "_stopped"}, stopped, 1);
        check({name, "_no_cmd"}, cmd_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc;
        int cnt_valid;
        int cnt_run;

        // Reset values
        tick(3);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_cmd_len", cmd_len, 0);
        check("rst_frame_irq", frame_irq, 0);
        check("rst_clear_go", clear_go, 0);
        check("rst_stopped", stopped, 1);
        rst = 1'b1;
        tick(2);

        // 70-word frame, first command stalled 5 cycles, go dropped mid-frame
        expect_cmd(32'h1000, 32);
        expect_cmd(32'h1080, 32);
        expect_cmd(32'h1100, 6);
        expect_irq(70, 1'b0);
        commit(32'h1000, 24'd70, 1'b0);
        cmd_ready = 1'b0;
        go = 1'b1;
        base_acc = n_acc;
        wait_valid("t70_valid_timeout");
        check("t70_not_stopped", stopped, 0);
        tick(5);
        cmd_ready = 1'b1;
        wait_accepts(base_acc + 1, "t70_accept_timeout");
        go = 1'b0;
        wait_idle("t70");

        // 64-word frame, go dropped after first command
        expect_cmd(32'h2000, 32);
        expect_cmd(32'h2080, 32);
        expect_irq(64, 1'b0);
        commit(32'h2000, 24'd64, 1'b0);
        go = 1'b1;
        base_acc = n_acc;
        wait_accepts(base_acc + 1, "t64_accept_timeout");
        go = 1'b0;
        wait_idle("t64");
        tick(20);
        check("t64_stays_stopped", stopped, 1);

        // One-shot 8-word frame
        expect_cmd(32'h3000, 8);
        expect_irq(8, 1'b1);
        commit(32'h3000, 24'd8, 1'b1);
        go = 1'b1;
        wait_clear_go("t8_clear_go_timeout");
        wait_idle("t8");

        // Mid-frame commit applies only to the following frame
        expect_cmd(32'h4000, 32);
        expect_cmd(32'h4080, 8);
        expect_irq(40, 1'b0);
        expect_cmd(32'h5000, 16);
        expect_irq(16, 1'b1);
        commit(32'h4000, 24'd40, 1'b0);
        go = 1'b1;
        base_acc = n_acc;
        wait_accepts(base_acc + 1, "t40_accept_timeout");
        commit(32'h5000, 24'd16, 1'b1);
        wait_clear_go("t40_clear_go_timeout");
        wait_idle("t40");

        // Reset while a command is waiting
        commit(32'h6000, 24'd40, 1'b0);
        cmd_ready = 1'b0;
        go = 1'b1;
        wait_valid("trst_valid_timeout");
        tick(2);
        rst = 1'b0;
        #1;
        check("trst_cmd_valid", cmd_valid, 0);
        check("trst_stopped", stopped, 1);
        check("trst_frame_irq", frame_irq, 0);
        tick(2);
        rst = 1'b1;
        cmd_ready = 1'b1;
        cnt_valid = 0;
        cnt_run = 0;
        repeat (10) begin
            tick(1);
            if (cmd_valid) cnt_valid++;
            if (!stopped) cnt_run++;
        end
        check("trst_no_cmd_after", cnt_valid, 0);
        check("trst_stays_stopped", cnt_run, 0);
        expect_cmd(32'h7000, 12);
        expect_irq(12, 1'b1);
        commit(32'h7000, 24'd12, 1'b1);
        wait_clear_go("trst_clear_go_timeout");
        wait_idle("trst");

        // Zero-word commit invalidates the shadow
        commit(32'h8000, 24'd0, 1'b0);
        go = 1'b1;
        cnt_valid = 0;
        cnt_run = 0;
        repeat (10) begin
            tick(1);
            if (cmd_valid) cnt_valid++;
            if (!stopped) cnt_run++;
        end
        check("tzero_no_cmd", cnt_valid, 0);
        check("tzero_stopped", cnt_run, 0);
        go = 1'b0;
        tick(3);

        check("leftover_cmds", exp_addr.size(), 0);
        check("leftover_irqs", exp_irq_total.size(), 0);
        check("total_rd_words", total_rd, exp_total);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vfr_frame_scheduler.md
VFR_FRAME_SCHEDULER -- requirements
Module: vfr_frame_scheduler

Parameters
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Avalon byte address width of read commands.
REQ-002 SHALL have parameter WORDS_WIDTH, default 24, width of frame word counts.
REQ-003 SHALL have parameter MAX_BURST, default 32, max words per read command (power of two, 1..256).
REQ-004 SHALL have parameter BYTES_PER_WORD, default 4, address increment per word (power of two).

Interface
REQ-005 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port go  input  1  run enable, from control slave enable bit.
REQ-008 SHALL have port cfg_base_addr  input  ADDR_WIDTH  frame base byte address.
REQ-009 SHALL have port cfg_words  input  WORDS_WIDTH  words per frame.
REQ-010 SHALL have port cfg_one_shot  input  1  stop after one frame.
REQ-011 SHALL have port cfg_commit  input  1  one-cycle pulse latching cfg_* into pending shadow.
REQ-012 SHALL have port cmd_valid  output  1  read command valid.
REQ-013 SHALL have port cmd_ready  input  1  read master accepts command.
REQ-014 SHALL have port cmd_addr  output  ADDR_WIDTH  command byte address.
REQ-015 SHALL have port cmd_len  output  clog2(MAX_BURST)+1  command length in words.
REQ-016 SHALL have port rd_done  input  1  one pulse per returned data word.
REQ-017 SHALL have port frame_irq  output  1  one-cycle end-of-frame pulse, feeds interrupts[0].
REQ-018 SHALL have port clear_go  output  1  one-cycle pulse, feeds clear_enable.
REQ-019 SHALL have port stopped  output  1  high only in IDLE, feeds stopped.

Function
REQ-020 SHALL hold pending shadow {base, words, one_shot, pending_valid}; cfg_commit with cfg_words!=0 loads it and sets pending_valid; cfg_commit with cfg_words==0 clears pending_valid.
REQ-021 SHALL implement states IDLE, START, ISSUE, DRAIN.
REQ-022 IDLE: stopped=1; go && pending_valid -> START, else stay.
REQ-023 START (one cycle): copy pending to active; cur_addr=base; cmd_rem=words; data_rem=words; -> ISSUE. pending_valid stays set (reused every frame).
REQ-024 ISSUE: cmd_valid=1, cmd_addr=cur_addr, cmd_len=min(cmd_rem, MAX_BURST); cmd_addr/cmd_len stable while cmd_valid && !cmd_ready.
REQ-025 On cmd_valid && cmd_ready: cur_addr += cmd_len*BYTES_PER_WORD (mod 2^ADDR_WIDTH); cmd_rem -= cmd_len; if new cmd_rem==0 -> DRAIN with cmd_valid=0 next cycle, else next command presented next cycle.
REQ-026 data_rem SHALL decrement on every rd_done in START-after-load, ISSUE, DRAIN; rd_done with data_rem==0 or in IDLE ignored.
REQ-027 DRAIN: when data_rem==0 (including same-cycle last rd_done), pulse frame_irq one cycle; then if active one_shot: pulse clear_go same cycle, -> IDLE; else if go -> START; else -> IDLE.
REQ-028 go deassertion mid-frame SHALL NOT abort; frame completes, then IDLE.
REQ-029 cfg_commit during a frame SHALL NOT affect active frame; applied at next START.
REQ-030 Command/word accounting SHALL use WORDS_WIDTH unsigned arithmetic, no overflow since decrements never exceed remaining.
REQ-031 cmd_valid, cmd_addr, cmd_len, frame_irq, clear_go, stopped SHALL be registered outputs.

Reset
REQ-032 On rst low: state=IDLE, pending_valid=0, cmd_valid=0, cmd_addr=0, cmd_len=0, frame_irq=0, clear_go=0, stopped=1, counters=0; asserted mid-frame abandons it with no frame_irq.

Structure
REQ-033 State encoding and clog2 helper SHALL live in shared package vfr_sched_pkg.
REQ-034 SHALL be one module; burst-length min() computed inline, no sub-module.

Verification
REQ-035 commit base=0x1000 words=70, MAX_BURST=32, go=1 -> commands (0x1000,32),(0x1080,32),(0x1100,6); frame_irq after 70th rd_done.
REQ-036 cmd_ready held low 5 cycles on first command -> cmd_addr/cmd_len unchanged for those cycles.
REQ-037 one_shot=1, words=8 -> one frame, frame_irq and clear_go same cycle, then stopped=1.
REQ-038 go dropped after first command of a 64-word frame -> frame finishes, one frame_irq, stopped=1, no further commands.
REQ-039 commit words=16 mid-frame of words=40 -> current frame 40 words, next frame 16 words.
REQ-040 rst low during ISSUE -> cmd_valid=0, stopped=1 immediately; after release no command until new commit and go.
